// File: rtl/memory_round_engine.sv
// Round sequencer for the memory game: draws a pseudo-random item each round,
// flags repeats against a short circular history, and turns a debounced key
// press into a clean one-cycle active-low strobe for the display stage.
module memory_round_engine #(
  parameter int unsigned ITEM_W          = 4,
  parameter int unsigned HIST_DEPTH      = 8,
  parameter int unsigned ROUNDS          = 20,
  parameter int unsigned SHOW_CYCLES     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              key_n,
  output logic              key_out,
  output logic              exist,
  output logic [ITEM_W-1:0] item,
  output logic              item_valid,
  output logic [2:0]        display_state,
  output logic [6:0]        round_count
);

  localparam int unsigned PTR_W = $clog2(HIST_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [15:0]      SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIST_FULL = CNT_W'(HIST_DEPTH);
  localparam logic [6:0]       LAST_RND  = 7'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GEN    = 3'd1,
    S_SHOW   = 3'd2,
    S_COMMIT = 3'd3
  } state_t;

  state_t state, state_n;
  logic   key_out_n;

  logic            key_s1, key_s2;
  logic            deb_level;
  logic [DB_W-1:0] deb_cnt;
  logic            press_evt;

  logic [15:0]      lfsr;
  logic [15:0]      lfsr_shift;
  logic [ITEM_W-1:0] new_item;
  logic             hit;

  logic [ITEM_W-1:0] hist [HIST_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  valid_cnt;
  logic [TMR_W-1:0]  show_tmr;
  logic [6:0]        round_inc;

  assign display_state = state;
  assign round_inc     = round_count + 7'd1;

  // Synchronize the raw key, debounce it, and pulse on an accepted press
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_s1    <= 1'b1;
      key_s2    <= 1'b1;
      deb_level <= 1'b1;
      deb_cnt   <= '0;
      press_evt <= 1'b0;
    end else begin
      key_s1    <= key_n;
      key_s2    <= key_s1;
      press_evt <= 1'b0;
      if (key_s2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DB_LAST) begin
        deb_level <= key_s2;
        deb_cnt   <= '0;
        press_evt <= ~key_s2;
      end else begin
        deb_cnt <= deb_cnt + DB_W'(1);
      end
    end
  end

  // Next LFSR value and repeat lookup against the valid history entries
  always_comb begin
    lfsr_shift = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    new_item   = lfsr_shift[ITEM_W-1:0];
    hit        = 1'b0;
    for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
      if ((CNT_W'(i) < valid_cnt) && (hist[i] == new_item)) begin
        hit = 1'b1;
      end
    end
  end

  // Next-state and strobe decode; a press beats a same-cycle timeout
  always_comb begin
    state_n   = state;
    key_out_n = 1'b1;
    case (state)
      S_IDLE:   if (start) state_n = S_GEN;
      S_GEN:    state_n = S_SHOW;
      S_SHOW: begin
        if (press_evt) begin
          state_n   = S_COMMIT;
          key_out_n = 1'b0;
        end else if (show_tmr == SHOW_LAST) begin
          state_n = S_COMMIT;
        end
      end
      S_COMMIT: state_n = (round_inc == LAST_RND) ? S_IDLE : S_GEN;
      default:  state_n = S_IDLE;
    endcase
  end

  // State, outputs and round bookkeeping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      key_out     <= 1'b1;
      exist       <= 1'b0;
      item        <= '0;
      item_valid  <= 1'b0;
      round_count <= '0;
      lfsr        <= SEED;
      wr_ptr      <= '0;
      valid_cnt   <= '0;
      show_tmr    <= '0;
    end else begin
      state      <= state_n;
      key_out    <= key_out_n;
      item_valid <= (state_n == S_SHOW);
      case (state)
        S_IDLE: begin
          if (start) begin
            round_count <= '0;
            valid_cnt   <= '0;
            wr_ptr      <= '0;
          end
        end
        S_GEN: begin
          lfsr     <= lfsr_shift;
          item     <= new_item;
          exist    <= hit;
          show_tmr <= '0;
        end
        S_SHOW: show_tmr <= show_tmr + TMR_W'(1);
        S_COMMIT: begin
          wr_ptr      <= wr_ptr + PTR_W'(1);
          round_count <= round_inc;
          if (valid_cnt != HIST_FULL) valid_cnt <= valid_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // History storage; entries beyond valid_cnt are never consulted, so no reset
  always_ff @(posedge clk) begin
    if (state == S_COMMIT) hist[wr_ptr] <= item;
  end

endmodule

// File: tb/tb_memory_round_engine.sv
// Scoreboard bench: a per-game reference model queues expected items/exist
// flags and per-round strobe expectations; a negedge monitor checks them.
module tb_memory_round_engine;

  localparam int unsigned ITEM_W     = 2;
  localparam int unsigned HIST_DEPTH = 4;
  localparam int unsigned ROUNDS     = 20;
  localparam int unsigned SHOW_CYC   = 64;
  localparam int unsigned DEB_CYC    = 8;
  localparam int          SEED       = 'hACE1;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic              key_n;
  logic              key_out;
  logic              exist;
  logic [ITEM_W-1:0] item;
  logic              item_valid;
  logic [2:0]        display_state;
  logic [6:0]        round_count;

  typedef struct {
    int item;
    bit ex;
    int rnd;
  } exp_t;

  exp_t exp_q[$];
  bit   kq[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   rounds_seen = 0;
  int   m_lfsr = SEED;

  memory_round_engine #(
    .ITEM_W(ITEM_W), .HIST_DEPTH(HIST_DEPTH), .ROUNDS(ROUNDS),
    .SHOW_CYCLES(SHOW_CYC), .DEBOUNCE_CYCLES(DEB_CYC), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .key_n(key_n),
    .key_out(key_out), .exist(exist), .item(item), .item_valid(item_valid),
    .display_state(display_state), .round_count(round_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int lfsr_next(input int s);
    int fb;
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return ((s << 1) | fb) & 'hFFFF;
  endfunction

  // Expected item/exist for every round of one game
  task automatic model_game();
    int hist[$];
    int it;
    bit ex;
    for (int r = 0; r < int'(ROUNDS); r++) begin
      m_lfsr = lfsr_next(m_lfsr);
      it = m_lfsr % (1 << ITEM_W);
      ex = 0;
      foreach (hist[k]) if (hist[k] == it) ex = 1;
      exp_q.push_back('{item: it, ex: ex, rnd: r});
      hist.push_back(it);
      if (hist.size() > int'(HIST_DEPTH)) void'(hist.pop_front());
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic hold_key(input int len);
    key_n = 1'b0;
    repeat (len) cyc();
    key_n = 1'b1;
    repeat (14) cyc();
  endtask

  task automatic wait_rounds(input int n);
    int c = 0;
    while (rounds_seen < n && c < 2000) begin
      cyc();
      c++;
    end
    if (c >= 2000) chk("round_wait_timeout", rounds_seen, n);
  endtask

  // mode 0: random keys; 1: key held across start + start in SHOW; 2: reset abort
  task automatic run_game(input int mode);
    int base;
    int a;
    int c;
    base = rounds_seen;
    if (mode == 1) begin
      key_n = 1'b0;
      repeat (15) cyc();
    end
    model_game();
    pulse_start();
    for (int r = 0; r < int'(ROUNDS); r++) begin
      wait_rounds(base + r + 1);
      if (mode == 1 && r == 0) begin
        kq.push_back(1'b0);
        repeat (6) cyc();
        key_n = 1'b1;
        repeat (14) cyc();
      end else if (mode == 1 && r == 3) begin
        kq.push_back(1'b0);
        pulse_start();
      end else if (mode == 2 && r == 2) begin
        kq.push_back(1'b0);
        repeat (5) cyc();
        resetn = 1'b0;
        #1;
        chk("rst_key_out", key_out, 1);
        chk("rst_exist", exist, 0);
        chk("rst_item_valid", item_valid, 0);
        chk("rst_state", display_state, 0);
        chk("rst_round_count", round_count, 0);
        exp_q.delete();
        kq.delete();
        m_lfsr = SEED;
        repeat (3) cyc();
        resetn = 1'b1;
        cyc();
        return;
      end else begin
        a = $urandom_range(0, 2);
        kq.push_back(a == 1);
        repeat ($urandom_range(0, 7)) cyc();
        if (a == 1) hold_key(20);
        else if (a == 2) hold_key(5);
      end
    end
    c = 0;
    while (display_state != 3'd0 && c < 400) begin
      cyc();
      c++;
    end
    chk("idle_reached", display_state, 0);
    chk("final_round_count", round_count, ROUNDS);
  endtask

  // Monitor: checks each shown item and the strobe at the end of each SHOW
  initial begin
    bit   prev_v = 0;
    bit   prev_key = 1;
    bit   kp;
    int   show_len = 0;
    exp_t cur = '{item: 0, ex: 0, rnd: 0};
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_v = 0;
        prev_key = 1;
        show_len = 0;
        continue;
      end
      if (!key_out) chk("key_low_outside_commit", display_state, 3);
      if (!prev_key) chk("key_pulse_width", key_out, 1);
      if (item_valid && !prev_v) begin
        rounds_seen++;
        show_len = 1;
        if (exp_q.size() == 0) begin
          chk("exp_q_underflow", 0, 1);
        end else begin
          cur = exp_q.pop_front();
          chk("item", item, cur.item);
          chk("exist", exist, cur.ex);
          chk("round_count_at_show", round_count, cur.rnd);
          chk("show_state", display_state, 2);
        end
      end else if (item_valid) begin
        show_len++;
      end
      if (!item_valid && prev_v) begin
        if (kq.size() == 0) begin
          chk("kq_underflow", 0, 1);
        end else begin
          kp = kq.pop_front();
          chk("strobe", key_out, kp ? 0 : 1);
          if (kp) begin
            chk("exist_at_strobe", exist, cur.ex);
            chk("item_at_strobe", item, cur.item);
          end else begin
            chk("show_len_timeout", show_len, SHOW_CYC);
          end
        end
      end
      prev_v = item_valid;
      prev_key = key_out;
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    key_n  = 1'b1;
    repeat (3) cyc();
    chk("reset_key_out", key_out, 1);
    chk("reset_exist", exist, 0);
    chk("reset_item", item, 0);
    chk("reset_item_valid", item_valid, 0);
    chk("reset_state", display_state, 0);
    chk("reset_round_count", round_count, 0);
    resetn = 1'b1;
    repeat (2) cyc();
    run_game(0);
    repeat (5) cyc();
    run_game(1);
    repeat (5) cyc();
    run_game(2);
    repeat (5) cyc();
    run_game(0);
    repeat (5) cyc();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("kq_drained", kq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
